// File: rtl/hilo_ctrl.sv
// HI/LO controller: issues multiplier/divider handshakes, stalls EX until
// the 64-bit result returns, and holds the architectural HI/LO registers.
module hilo_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        mul_start_o,
    output logic        mul_signed_o,
    output logic        mul_annul_o,
    output logic [31:0] mul_op1_o,
    output logic [31:0] mul_op2_o,
    input  logic [63:0] mul_result_i,
    input  logic        mul_ready_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic        div_annul_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        DIV_WAIT,
        RELEASE
    } state_t;

    state_t state;

    logic is_mul;
    logic is_div;
    logic div_ok;

    assign is_mul = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
    // A zero divisor never reaches the divider and retires without a stall.
    assign div_ok = is_div && (rt_i != 32'd0);

    always_comb begin
        stall_o = 1'b0;
        if (!flush_i) begin
            case (state)
                IDLE:     stall_o = is_mul || div_ok;
                MUL_WAIT: stall_o = !mul_ready_i;
                DIV_WAIT: stall_o = !div_ready_i;
                RELEASE:  stall_o = is_mul || is_div;
                default:  stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mul_start_o  <= 1'b0;
            mul_signed_o <= 1'b0;
            mul_annul_o  <= 1'b0;
            mul_op1_o    <= 32'd0;
            mul_op2_o    <= 32'd0;
            div_start_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_annul_o  <= 1'b0;
            div_op1_o    <= 32'd0;
            div_op2_o    <= 32'd0;
            hi_o         <= 32'd0;
            lo_o         <= 32'd0;
        end else begin
            mul_annul_o <= 1'b0;
            div_annul_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!flush_i) begin
                        if (is_mul) begin
                            mul_op1_o    <= rs_i;
                            mul_op2_o    <= rt_i;
                            mul_signed_o <= (op_i == OP_MULT);
                            mul_start_o  <= 1'b1;
                            state        <= MUL_WAIT;
                        end else if (div_ok) begin
                            div_op1_o    <= rs_i;
                            div_op2_o    <= rt_i;
                            div_signed_o <= (op_i == OP_DIV);
                            div_start_o  <= 1'b1;
                            state        <= DIV_WAIT;
                        end else if (op_i == OP_MTHI) begin
                            hi_o <= rs_i;
                        end else if (op_i == OP_MTLO) begin
                            lo_o <= rs_i;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (flush_i) begin
                        mul_start_o <= 1'b0;
                        mul_annul_o <= 1'b1;
                        state       <= IDLE;
                    end else if (mul_ready_i) begin
                        hi_o        <= mul_result_i[63:32];
                        lo_o        <= mul_result_i[31:0];
                        mul_start_o <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                DIV_WAIT: begin
                    if (flush_i) begin
                        div_start_o <= 1'b0;
                        div_annul_o <= 1'b1;
                        state       <= IDLE;
                    end else if (div_ready_i) begin
                        hi_o        <= div_result_i[63:32];
                        lo_o        <= div_result_i[31:0];
                        div_start_o <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Start stays low here so the unit sees a free cycle.
                    state <= IDLE;
                    if (!flush_i) begin
                        if (op_i == OP_MTHI) begin
                            hi_o <= rs_i;
                        end else if (op_i == OP_MTLO) begin
                            lo_o <= rs_i;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: behavioural mul/div units, vector table with a
// result scoreboard, plus hand sequences for release, flush and reset.
module tb_hilo_ctrl;

    localparam int MLAT = 35;
    localparam int DLAT = 20;
    localparam int BUD  = 200;

    logic        clk;
    logic        rst;
    logic [2:0]  op_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic        flush_i;
    logic        stall_o;
    logic        mul_start_o;
    logic        mul_signed_o;
    logic        mul_annul_o;
    logic [31:0] mul_op1_o;
    logic [31:0] mul_op2_o;
    logic [63:0] mul_result_i;
    logic        mul_ready_i;
    logic        div_start_o;
    logic        div_signed_o;
    logic        div_annul_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    hilo_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .op_i         (op_i),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .mul_start_o  (mul_start_o),
        .mul_signed_o (mul_signed_o),
        .mul_annul_o  (mul_annul_o),
        .mul_op1_o    (mul_op1_o),
        .mul_op2_o    (mul_op2_o),
        .mul_result_i (mul_result_i),
        .mul_ready_i  (mul_ready_i),
        .div_start_o  (div_start_o),
        .div_signed_o (div_signed_o),
        .div_annul_o  (div_annul_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier and divider.
    int          mcnt;
    int          dcnt;
    logic [31:0] dq;
    logic [31:0] dr;

    always_comb begin
        if (mul_signed_o)
            mul_result_i = 64'(longint'($signed(mul_op1_o)) * longint'($signed(mul_op2_o)));
        else
            mul_result_i = {32'd0, mul_op1_o} * {32'd0, mul_op2_o};
    end

    always_comb begin
        dq = 32'd0;
        dr = 32'd0;
        if (div_op2_o != 32'd0) begin
            if (div_signed_o) begin
                dq = $signed(div_op1_o) / $signed(div_op2_o);
                dr = $signed(div_op1_o) % $signed(div_op2_o);
            end else begin
                dq = div_op1_o / div_op2_o;
                dr = div_op1_o % div_op2_o;
            end
        end
        div_result_i = {dr, dq};
    end

    always @(posedge clk) begin
        if (rst || !mul_start_o) begin
            mcnt        <= 0;
            mul_ready_i <= 1'b0;
        end else begin
            mcnt        <= mcnt + 1;
            mul_ready_i <= (mcnt == MLAT - 1);
        end
    end

    always @(posedge clk) begin
        if (rst || !div_start_o) begin
            dcnt        <= 0;
            div_ready_i <= 1'b0;
        end else begin
            dcnt        <= dcnt + 1;
            div_ready_i <= (dcnt == DLAT - 1);
        end
    end

    // Start/sign monitor over each transaction window.
    int   mul_starts;
    int   div_starts;
    logic mul_sgn_seen;
    logic div_sgn_seen;

    always @(negedge clk) begin
        if (mul_start_o) begin
            mul_starts   = mul_starts + 1;
            mul_sgn_seen = mul_signed_o;
        end
        if (div_start_o) begin
            div_starts   = div_starts + 1;
            div_sgn_seen = div_signed_o;
        end
    end

    int nvec;
    int nerr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        stall;
        int          unit;
        logic        sgn;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic [63:0] sb[$];

    task automatic run_op(input vec_t v, input string name);
        int          cyc;
        logic        stalled;
        logic [63:0] exp;
        mul_starts = 0;
        div_starts = 0;
        op_i = v.op;
        rs_i = v.rs;
        rt_i = v.rt;
        sb.push_back({v.hi, v.lo});
        #1;
        cyc     = 0;
        stalled = 1'b0;
        while (stall_o && cyc < BUD) begin
            stalled = 1'b1;
            tick();
            cyc++;
        end
        chk({name, "_timeout"}, 64'(cyc < BUD), 64'(1));
        tick();
        op_i = 3'b000;
        rs_i = 32'd0;
        rt_i = 32'd0;
        tick();
        exp = sb.pop_front();
        chk({name, "_hilo"}, {hi_o, lo_o}, exp);
        chk({name, "_stall"}, 64'(stalled), 64'(v.stall));
        chk({name, "_mstart"}, 64'(mul_starts != 0), 64'(v.unit == 1));
        chk({name, "_dstart"}, 64'(div_starts != 0), 64'(v.unit == 2));
        if (v.unit == 1) chk({name, "_msgn"}, 64'(mul_sgn_seen), 64'(v.sgn));
        if (v.unit == 2) chk({name, "_dsgn"}, 64'(div_sgn_seen), 64'(v.sgn));
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_ctl"}, 64'({stall_o, mul_start_o, mul_signed_o, mul_annul_o,
                                  div_start_o, div_signed_o, div_annul_o}), 64'd0);
        chk({name, "_mops"}, {mul_op1_o, mul_op2_o}, 64'd0);
        chk({name, "_dops"}, {div_op1_o, div_op2_o}, 64'd0);
        chk({name, "_hilo"}, {hi_o, lo_o}, 64'd0);
    endtask

    vec_t tv[10];

    initial begin
        int cyc;
        nvec = 0;
        nerr = 0;
        mul_starts = 0;
        div_starts = 0;
        mul_sgn_seen = 1'b0;
        div_sgn_seen = 1'b0;
        rst = 1'b1;
        op_i = 3'b000;
        rs_i = 32'd0;
        rt_i = 32'd0;
        flush_i = 1'b0;

        tv[0] = '{3'b101, 32'hA5A5A5A5, 32'h0, 1'b0, 0, 1'b0, 32'hA5A5A5A5, 32'h0};
        tv[1] = '{3'b110, 32'h5A5A5A5A, 32'h0, 1'b0, 0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A};
        tv[2] = '{3'b001, 32'hFFFFFFFD, 32'h5, 1'b1, 1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tv[3] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1, 1'b0, 32'hFFFFFFFE, 32'h1};
        tv[4] = '{3'b011, 32'hFFFFFFF9, 32'h2, 1'b1, 2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tv[5] = '{3'b100, 32'h7, 32'h0, 1'b0, 0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tv[6] = '{3'b100, 32'd100, 32'd7, 1'b1, 2, 1'b0, 32'h2, 32'hE};
        tv[7] = '{3'b111, 32'h1234, 32'h5, 1'b0, 0, 1'b0, 32'h2, 32'hE};
        tv[8] = '{3'b010, 32'h10000, 32'h10000, 1'b1, 1, 1'b0, 32'h1, 32'h0};
        tv[9] = '{3'b101, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1'b0, 32'hDEADBEEF, 32'h0};

        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_op(tv[i], $sformatf("vec%0d", i));

        // MULT then DIV back to back through RELEASE.
        op_i = 3'b001;
        rs_i = 32'hFFFFFFFD;
        rt_i = 32'h5;
        cyc = 0;
        while (!mul_ready_i && cyc < BUD) begin
            tick();
            cyc++;
        end
        chk("b2b_timeout", 64'(cyc < BUD), 64'(1));
        chk("b2b_stall_at_ready", 64'(stall_o), 64'(0));
        tick();
        op_i = 3'b011;
        rs_i = 32'hFFFFFFF9;
        rt_i = 32'h2;
        #1;
        chk("rel_mstart", 64'(mul_start_o), 64'(0));
        chk("rel_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF1);
        chk("rel_stall", 64'(stall_o), 64'(1));
        tick();
        chk("idle_dstart", 64'(div_start_o), 64'(0));
        chk("idle_stall", 64'(stall_o), 64'(1));
        tick();
        chk("dstart_2cyc", 64'(div_start_o), 64'(1));
        chk("dstart_mstart", 64'(mul_start_o), 64'(0));
        cyc = 0;
        while (stall_o && cyc < BUD) begin
            tick();
            cyc++;
        end
        chk("b2b_div_timeout", 64'(cyc < BUD), 64'(1));
        tick();
        op_i = 3'b000;
        rs_i = 32'd0;
        rt_i = 32'd0;
        tick();
        chk("b2b_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);

        // Flush ten cycles into a MULT.
        op_i = 3'b001;
        rs_i = 32'd7;
        rt_i = 32'd9;
        tick();
        repeat (9) tick();
        chk("fl_mstart", 64'(mul_start_o), 64'(1));
        flush_i = 1'b1;
        #1;
        chk("fl_stall", 64'(stall_o), 64'(0));
        tick();
        flush_i = 1'b0;
        op_i = 3'b000;
        rs_i = 32'd0;
        rt_i = 32'd0;
        #1;
        chk("fl_annul", 64'(mul_annul_o), 64'(1));
        chk("fl_start", 64'(mul_start_o), 64'(0));
        chk("fl_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
        tick();
        chk("fl_annul_1cyc", 64'(mul_annul_o), 64'(0));
        op_i = 3'b110;
        rs_i = 32'h12345678;
        tick();
        op_i = 3'b000;
        rs_i = 32'd0;
        chk("mtlo_after_fl", {hi_o, lo_o}, 64'hFFFFFFFF_12345678);

        // Flush coinciding with divider ready: no HI/LO write.
        op_i = 3'b100;
        rs_i = 32'd50;
        rt_i = 32'd5;
        cyc = 0;
        while (!div_ready_i && cyc < BUD) begin
            tick();
            cyc++;
        end
        chk("flr_timeout", 64'(cyc < BUD), 64'(1));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        op_i = 3'b000;
        rs_i = 32'd0;
        rt_i = 32'd0;
        chk("flr_annul", 64'(div_annul_o), 64'(1));
        chk("flr_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_12345678);
        tick();

        // Reset in the middle of DIV_WAIT.
        op_i = 3'b011;
        rs_i = 32'd100;
        rt_i = 32'd3;
        tick();
        repeat (5) tick();
        chk("rdiv_start", 64'(div_start_o), 64'(1));
        rst = 1'b1;
        op_i = 3'b000;
        rs_i = 32'd0;
        rt_i = 32'd0;
        tick();
        chk_reset("midrst");
        rst = 1'b0;
        tick();
        run_op('{3'b001, 32'd2, 32'd3, 1'b1, 1, 1'b1, 32'h0, 32'h6}, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
